param_updown_counter: RTL and testbench
=======================================

Name: param_updown_counter

Overview:
Parametrised successor to the free-running 32-bit counter. Adds configurable width, modulo wrap limit, prescaler, up/down direction, synchronous load, compare match, a terminal-count pulse and sticky overflow/underflow flags. Serves as the general-purpose counter/timer primitive for later blocks (timers, baud generators, event counters).

Parameters:
WIDTH, 32, counter width in bits
MAX_COUNT, 2**WIDTH-1, count range is 0..MAX_COUNT; legal values 1 <= MAX_COUNT <= 2**WIDTH-1
PRESCALE, 1, count steps once every PRESCALE enabled cycles; must be >= 1

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  reset, synchronous, active-low (rst==0 at a rising edge resets)
en  in  1  count enable; prescaler and counter hold when low
up_dn  in  1  direction, 1=up, 0=down; sampled on step cycles only
load  in  1  synchronous load of load_val
load_val  in  WIDTH  value to load
clr_flags  in  1  clears ovf/unf
cmp_val  in  WIDTH  compare value
count  out  WIDTH  registered count
tc  out  1  registered one-cycle terminal-count pulse on wrap
ovf  out  1  sticky: up-wrap occurred
unf  out  1  sticky: down-wrap occurred
match  out  1  combinational, count==cmp_val

Behaviour:
- Reset (rst==0 at edge): count=0, prescaler=0, tc=0, ovf=0, unf=0. Overrides every other input.
- Priority per edge: reset > load > step > hold.
- Prescaler psc runs 0..PRESCALE-1. It increments only when en=1. step = en && psc==PRESCALE-1. psc returns to 0 on step, on load, and on reset. It holds while en=0. With PRESCALE=1, step = en.
- Load: count <= min(load_val, MAX_COUNT). tc=0 that cycle. Flags unchanged. A coincident step is discarded.
- Step, up: count==MAX_COUNT gives count<=0, tc<=1, ovf<=1. Otherwise count+1.
- Step, down: count==0 gives count<=MAX_COUNT, tc<=1, unf<=1. Otherwise count-1.
- tc is high for exactly the one cycle in which count shows the wrapped value. Otherwise 0.
- Back-to-back wraps are possible (MAX_COUNT small, PRESCALE=1, direction toggling). tc then stays high on consecutive cycles; each is a separate event.
- clr_flags clears ovf and unf. If a wrap occurs in the same cycle, the set wins for that flag.
- The arithmetic never leaves 0..MAX_COUNT and uses no WIDTH+1 intermediate except for the clamp compare.
- match is purely combinational from count and cmp_val. It has zero latency relative to count.
- Reset mid-prescale discards partial prescaler progress. Changing up_dn between steps has no effect until the next step.
- Elaboration-time checks on illegal MAX_COUNT or PRESCALE raise a fatal error.

Decomposition:
- Package counter_pkg holds:
  - DIR_UP=1'b1 and DIR_DOWN=1'b0 constants
  - a clog2 helper used to size psc, width max(1, clog2(PRESCALE))
- One sub-module, counter_prescaler (params PRESCALE; ports clk, rst, en, sync_clr, step), produces the step strobe.
- Wrap, load, flag and compare logic live in param_updown_counter.

Test Plan:
1. WIDTH=8, MAX_COUNT=9, PRESCALE=1; hold rst=0 for 2 cycles, then en=1, up_dn=1 for 12 cycles. Required:
   - count=0 throughout reset, then 1..9
   - then 0 with tc=1 for that single cycle and ovf=1, then 1
2. Same config, down from 0 (en=1, up_dn=0). Required: next count=9, tc=1, unf=1, then 8, 7; ovf unchanged.
3. PRESCALE=3, up. Required:
   - count increments every 3rd enabled cycle
   - en=0 for 5 cycles mid-period freezes count and psc
   - the step then completes the remaining cycles after en returns
4. load=1 with load_val=200 (MAX_COUNT=9). Required:
   - count=9 next cycle
   - load asserted on a wrap-step cycle gives count=load value, tc=0, flags unchanged
5. Set ovf via wrap, then assert clr_flags on the cycle of a fresh down-wrap. Required: ovf=0, unf=1. clr_flags alone later clears unf.
6. Drive rst=0 mid-count (count=5, psc=2, ovf=1). Required: next edge count=0, psc=0, tc=0, ovf=0, unf=0. With cmp_val=3, match=1 exactly while count==3.

Source files
------------

// File: rtl/param_updown_counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the parametrised up/down counter slice.
//   dir_e      : direction encoding carried on up_dn (DIR_UP=1, DIR_DOWN=0)
//   clog2      : ceiling log2 for constant expressions
//   psc_width  : prescaler register width, max(1, clog2(PRESCALE))
// ---------------------------------------------------------------------------
package counter_pkg;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned     bits;
      longint unsigned span;
      bits = 0;
      span = 1;
      while (span < longint'(value)) begin
         span = span << 1;
         bits++;
      end
      return bits;
   endfunction

   // A prescaler of 1 still needs a one-bit register so the port list and
   // compare logic stay uniform across all PRESCALE values.
   function automatic int unsigned psc_width(input int unsigned prescale);
      return (clog2(prescale) > 1) ? clog2(prescale) : 1;
   endfunction

endpackage

// File: rtl/param_updown_counter_if.sv
// ---------------------------------------------------------------------------
// param_updown_counter_if
// Control/status bundle of the up/down counter.
//   master : drives en, up_dn, load, load_val, clr_flags, cmp_val;
//            observes count, tc, ovf, unf, match
//   slave  : the counter itself (mirror directions)
// ---------------------------------------------------------------------------
interface param_updown_counter_if #(
   parameter int unsigned WIDTH = 32
) ();

   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             clr_flags;
   logic [WIDTH-1:0] cmp_val;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             ovf;
   logic             unf;
   logic             match;

   modport master (
      output en, up_dn, load, load_val, clr_flags, cmp_val,
      input  count, tc, ovf, unf, match
   );

   modport slave (
      input  en, up_dn, load, load_val, clr_flags, cmp_val,
      output count, tc, ovf, unf, match
   );

endinterface

// File: rtl/param_updown_counter_prescaler.sv
// ---------------------------------------------------------------------------
// counter_prescaler
// Divides enabled cycles by PRESCALE and emits a one-cycle step strobe.
//   clk      in  : clock, rising edge
//   rst      in  : synchronous reset, active low
//   en       in  : advance the prescaler; holds when low
//   sync_clr in  : restart the prescale period (used on load)
//   step     out : combinational, en && psc == PRESCALE-1
// ---------------------------------------------------------------------------
module counter_prescaler
   import counter_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic sync_clr,
   output logic step
);

   localparam int unsigned     PW       = psc_width(PRESCALE);
   localparam logic [PW-1:0]   PSC_LAST = PW'(PRESCALE - 1);

   if (PRESCALE < 1) begin : g_bad_prescale
      $fatal(1, "counter_prescaler: PRESCALE must be >= 1");
   end

   logic [PW-1:0] psc;

   assign step = en && (psc == PSC_LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         psc <= '0;
      end else if (sync_clr || step) begin
         psc <= '0;
      end else if (en) begin
         psc <= psc + PW'(1);
      end
   end

endmodule

// File: rtl/param_updown_counter.sv
// ---------------------------------------------------------------------------
// param_updown_counter
// General-purpose modulo up/down counter with prescaler, synchronous load,
// compare match, terminal-count pulse and sticky wrap flags.
//   clk   in : clock, rising edge
//   rst   in : synchronous reset, active low; overrides all other inputs
//   bus      : param_updown_counter_if.slave
//              en, up_dn, load, load_val, clr_flags, cmp_val  (inputs)
//              count, tc, ovf, unf (registered), match (combinational)
// Count range is 0..MAX_COUNT. Edge priority: reset > load > step > hold.
// ---------------------------------------------------------------------------
module param_updown_counter
   import counter_pkg::*;
#(
   parameter int unsigned      WIDTH     = 32,
   // One bit wider than the count so an out-of-range value is detectable.
   parameter logic [WIDTH:0]   MAX_COUNT = {1'b0, {WIDTH{1'b1}}},
   parameter int unsigned      PRESCALE  = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   param_updown_counter_if.slave  bus
);

   localparam logic [WIDTH:0]   FULL_RANGE = {1'b0, {WIDTH{1'b1}}};
   localparam logic [WIDTH-1:0] MAX_C      = MAX_COUNT[WIDTH-1:0];

   if (WIDTH < 1) begin : g_bad_width
      $fatal(1, "param_updown_counter: WIDTH must be >= 1");
   end
   if ((MAX_COUNT < (WIDTH+1)'(1)) || (MAX_COUNT > FULL_RANGE)) begin : g_bad_max
      $fatal(1, "param_updown_counter: MAX_COUNT must be in 1..2**WIDTH-1");
   end
   if (PRESCALE < 1) begin : g_bad_prescale
      $fatal(1, "param_updown_counter: PRESCALE must be >= 1");
   end

   logic             step;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic [WIDTH-1:0] load_clamped;

   // Load also restarts the prescale period, so a step coinciding with a
   // load is dropped and the next step is a full period away.
   counter_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.en),
      .sync_clr (bus.load),
      .step     (step)
   );

   // Clamp compare is the only place a WIDTH+1 quantity appears.
   always_comb begin
      load_clamped = bus.load_val;
      if ({1'b0, bus.load_val} > MAX_COUNT) begin
         load_clamped = MAX_C;
      end
   end

   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      // Clear first; a wrap on the same edge re-sets its flag below.
      ovf_d   = ovf_q && !bus.clr_flags;
      unf_d   = unf_q && !bus.clr_flags;

      if (bus.load) begin
         count_d = load_clamped;
      end else if (step) begin
         if (bus.up_dn == DIR_UP) begin
            if (count_q == MAX_C) begin
               count_d = '0;
               tc_d    = 1'b1;
               ovf_d   = 1'b1;
            end else begin
               count_d = count_q + WIDTH'(1);
            end
         end else begin
            if (count_q == '0) begin
               count_d = MAX_C;
               tc_d    = 1'b1;
               unf_d   = 1'b1;
            end else begin
               count_d = count_q - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign bus.count = count_q;
   assign bus.tc    = tc_q;
   assign bus.ovf   = ovf_q;
   assign bus.unf   = unf_q;
   assign bus.match = (count_q == bus.cmp_val);

endmodule

// File: tb/tb_param_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_param_updown_counter
// Directed bench for param_updown_counter. Two instances share clk/rst:
//   dut_a : WIDTH=8, MAX_COUNT=9, PRESCALE=1
//   dut_b : WIDTH=8, MAX_COUNT=9, PRESCALE=3
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_param_updown_counter;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   param_updown_counter_if #(.WIDTH(8)) ia ();
   param_updown_counter_if #(.WIDTH(8)) ib ();

   param_updown_counter #(
      .WIDTH     (8),
      .MAX_COUNT (9),
      .PRESCALE  (1)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ia)
   );

   param_updown_counter #(
      .WIDTH     (8),
      .MAX_COUNT (9),
      .PRESCALE  (3)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ib)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input int c, input bit t, input bit o, input bit u);
      chk({tag, ".count"}, 32'(ia.count), 32'(c));
      chk({tag, ".tc"},    32'(ia.tc),    32'(t));
      chk({tag, ".ovf"},   32'(ia.ovf),   32'(o));
      chk({tag, ".unf"},   32'(ia.unf),   32'(u));
   endtask

   task automatic chk_b(input string tag, input int c, input bit t, input bit o, input bit u);
      chk({tag, ".count"}, 32'(ib.count), 32'(c));
      chk({tag, ".tc"},    32'(ib.tc),    32'(t));
      chk({tag, ".ovf"},   32'(ib.ovf),   32'(o));
      chk({tag, ".unf"},   32'(ib.unf),   32'(u));
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b0;
      ia.en = 1'b0; ia.up_dn = 1'b1; ia.load = 1'b0; ia.load_val = '0;
      ia.clr_flags = 1'b0; ia.cmp_val = 8'd0;
      ib.en = 1'b0; ib.up_dn = 1'b1; ib.load = 1'b0; ib.load_val = '0;
      ib.clr_flags = 1'b0; ib.cmp_val = 8'd3;

      // 1. reset for two cycles, then count up 1..9, wrap to 0, then 1
      tick(); chk_a("rst0", 0, 0, 0, 0);
      tick(); chk_a("rst1", 0, 0, 0, 0); chk_b("rst1b", 0, 0, 0, 0);
      rst = 1'b1; ia.en = 1'b1; ia.up_dn = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         tick(); chk_a("up", i, 0, 0, 0);
      end
      tick(); chk_a("upwrap", 0, 1, 1, 0);
      tick(); chk_a("upafter", 1, 0, 1, 0);

      // 2. count down through 0; down-wrap to 9 sets unf, ovf stays
      ia.up_dn = 1'b0;
      tick(); chk_a("dn0", 0, 0, 1, 0);
      tick(); chk_a("dnwrap", 9, 1, 1, 1);
      tick(); chk_a("dn8", 8, 0, 1, 1);
      tick(); chk_a("dn7", 7, 0, 1, 1);
      ia.en = 1'b0;
      tick(); chk_a("hold", 7, 0, 1, 1);

      // 4. load clamps to MAX_COUNT; load beats a wrap step
      ia.load = 1'b1; ia.load_val = 8'd200;
      tick(); chk_a("ld200", 9, 0, 1, 1);
      ia.load = 1'b0; ia.clr_flags = 1'b1;
      tick(); chk_a("clronly", 9, 0, 0, 0);
      ia.clr_flags = 1'b0;
      ia.load = 1'b1; ia.load_val = 8'd4; ia.en = 1'b1; ia.up_dn = 1'b1;
      tick(); chk_a("ldwrap", 4, 0, 0, 0);
      ia.en = 1'b0; ia.load_val = 8'd10;
      tick(); chk_a("ld10", 9, 0, 0, 0);

      // 5. wrap up to set ovf, then clear on a down-wrap edge
      ia.load = 1'b0; ia.en = 1'b1; ia.up_dn = 1'b1;
      tick(); chk_a("ovfset", 0, 1, 1, 0);
      ia.up_dn = 1'b0; ia.clr_flags = 1'b1;
      tick(); chk_a("clrwrap", 9, 1, 0, 1);
      ia.en = 1'b0; ia.clr_flags = 1'b0;
      tick(); chk_a("unfhold", 9, 0, 0, 1);
      ia.clr_flags = 1'b1;
      tick(); chk_a("unfclr", 9, 0, 0, 0);
      ia.clr_flags = 1'b0;

      // 3. PRESCALE=3: step every 3rd enabled cycle, frozen while en=0
      ib.en = 1'b1; ib.up_dn = 1'b1;
      tick(); chk_b("p1", 0, 0, 0, 0);
      tick(); chk_b("p2", 0, 0, 0, 0);
      tick(); chk_b("p3", 1, 0, 0, 0);
      tick(); chk_b("p4", 1, 0, 0, 0);
      tick(); chk_b("p5", 1, 0, 0, 0);
      tick(); chk_b("p6", 2, 0, 0, 0);
      tick(); chk_b("p7", 2, 0, 0, 0);
      tick(); chk_b("p8", 2, 0, 0, 0);
      ib.en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(); chk_b("freeze", 2, 0, 0, 0);
      end
      ib.en = 1'b1;
      tick(); chk_b("resume", 3, 0, 0, 0);
      tick(); chk_b("p10", 3, 0, 0, 0);
      tick(); chk_b("p11", 3, 0, 0, 0);
      tick(); chk_b("p12", 4, 0, 0, 0);

      // 6. reset mid-prescale with ovf set; then compare match
      ib.load = 1'b1; ib.load_val = 8'd9; ib.en = 1'b0;
      tick(); chk_b("bld9", 9, 0, 0, 0);
      ib.load = 1'b0; ib.en = 1'b1;
      tick(); chk_b("bw1", 9, 0, 0, 0);
      tick(); chk_b("bw2", 9, 0, 0, 0);
      tick(); chk_b("bwrap", 0, 1, 1, 0);
      ib.load = 1'b1; ib.load_val = 8'd5;
      tick(); chk_b("bld5", 5, 0, 1, 0);
      ib.load = 1'b0;
      tick(); chk_b("bpsc1", 5, 0, 1, 0);
      tick(); chk_b("bpsc2", 5, 0, 1, 0);
      chk("match5", 32'(ib.match), 32'd0);
      rst = 1'b0;
      tick(); chk_b("brst", 0, 0, 0, 0);
      chk_a("arst", 0, 0, 0, 0);
      rst = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         tick();
         chk("bcnt", 32'(ib.count), 32'(j / 3));
         chk("match", 32'(ib.match), ((j / 3) == 3) ? 32'd1 : 32'd0);
      end
      // count is now 4; match must follow cmp_val without a clock edge
      ib.cmp_val = 8'd4;
      #1;
      chk("matchcomb", 32'(ib.match), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
